v_upd_arb: RTL and testbench

//  Round-robin arbiter sharing the single list-update bus of v between REQ_N producer-side requesters.

---
 rtl/v_upd_arb_pkg.sv | 29 ++
 rtl/v_upd_arb_if.sv | 26 ++
 rtl/v_upd_arb_rr.sv | 49 ++++
 rtl/v_upd_arb.sv | 158 +++++++++++++++
 tb/tb_v_upd_arb.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/v_upd_arb_pkg.sv
// Shared types and sizing for the v update-bus arbiter.
// The optional per-id spacing feature is enabled by the V_UPD_ARB_SPACING_EN macro.
package v_upd_arb_pkg;

    localparam int ID_W      = 4;
    localparam int CMD_W     = 2;
    localparam int KEY_W     = 8;
    localparam int SIZE_W    = 8;
    localparam int UPD_REQ_N = 4;

    typedef logic [ID_W-1:0]   id_t;
    typedef logic [CMD_W-1:0]  cmd_t;
    typedef logic [KEY_W-1:0]  key_t;
    typedef logic [SIZE_W-1:0] size_t;

    typedef enum logic [1:0] {
        BOOT      = 2'd0,
        WAIT_INIT = 2'd1,
        RUN       = 2'd2
    } arb_state_t;

    typedef struct packed {
        id_t   prod_id;
        cmd_t  cmd;
        key_t  key;
        size_t size;
    } upd_t;

endpackage

// File: rtl/v_upd_arb_if.sv
// Requester-side handshake bundle of the v update arbiter.
// Requesters drive the master modport; the arbiter uses the slave modport.
interface v_upd_arb_if
    import v_upd_arb_pkg::*;
#(
    parameter int REQ_N = UPD_REQ_N
);

    logic  [REQ_N-1:0] req_vld;
    id_t   [REQ_N-1:0] req_prod_id;
    cmd_t  [REQ_N-1:0] req_cmd;
    key_t  [REQ_N-1:0] req_key;
    size_t [REQ_N-1:0] req_size;
    logic  [REQ_N-1:0] req_rdy;

    modport master (
        output req_vld, req_prod_id, req_cmd, req_key, req_size,
        input  req_rdy
    );

    modport slave (
        input  req_vld, req_prod_id, req_cmd, req_key, req_size,
        output req_rdy
    );

endinterface

// File: rtl/v_upd_arb_rr.sv
// Combinational round-robin pick: rotate by the pointer, take the lowest set
// bit, then map the position back to a requester index.
module v_upd_arb_rr #(
    parameter  int REQ_N = 4,
    localparam int IDX_W = $clog2(REQ_N)
) (
    input  logic [REQ_N-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [REQ_N-1:0] gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [2*REQ_N-1:0] dbl_s;
    logic [REQ_N-1:0]   rot_s;
    logic [IDX_W-1:0]   pick_s;
    logic               found_s;
    logic [IDX_W:0]     sum_s;

    // rotate, priority-pick, unrotate
    always_comb begin
        dbl_s   = {req, req} >> ptr;
        rot_s   = dbl_s[REQ_N-1:0];
        pick_s  = '0;
        found_s = 1'b0;
        for (int k = 0; k < REQ_N; k++) begin
            if (rot_s[k] && !found_s) begin
                pick_s  = IDX_W'(k);
                found_s = 1'b1;
            end else begin
                pick_s  = pick_s;
                found_s = found_s;
            end
        end
        sum_s = {1'b0, ptr} + {1'b0, pick_s};
        if (sum_s >= (IDX_W+1)'(REQ_N)) begin
            idx = IDX_W'(sum_s - (IDX_W+1)'(REQ_N));
        end else begin
            idx = IDX_W'(sum_s);
        end
        any = found_s;
        if (found_s) begin
            gnt = REQ_N'(1) << idx;
        end else begin
            gnt = '0;
        end
    end

endmodule

// File: rtl/v_upd_arb.sv
// Round-robin arbiter for the v list-update bus with boot/init sequencing.
// Define V_UPD_ARB_SPACING_EN to enforce a minimum distance between equal prod_id updates.
module v_upd_arb
    import v_upd_arb_pkg::*;
#(
    parameter  int REQ_N    = UPD_REQ_N,
    parameter  int BOOT_CYC = 2,
    parameter  int SPACING  = 5,
    localparam int IDX_W    = $clog2(REQ_N),
    localparam int BCNT_W   = $clog2(BOOT_CYC + 1)
) (
    input  logic             clk,
    input  logic             rst,
    v_upd_arb_if.slave       req,
    input  logic             i_busy,
    output logic             o_upd_vld_r,
    output id_t              o_upd_prod_id_r,
    output cmd_t             o_upd_cmd_r,
    output key_t             o_upd_key_r,
    output size_t            o_upd_size_r,
    output logic [IDX_W-1:0] o_gnt_idx_r,
    output logic             o_ready_r
);

    arb_state_t        state_r;
    logic [BCNT_W-1:0] boot_cnt_r;
    logic [IDX_W-1:0]  ptr_r;
    logic [REQ_N-1:0]  blocked_s;
    logic [REQ_N-1:0]  cand_s;
    logic [REQ_N-1:0]  gnt_oh_s;
    logic [IDX_W-1:0]  idx_s;
    logic              any_s;
    logic              run_s;
    logic              grant_s;

`ifdef V_UPD_ARB_SPACING_EN
    // An update issued at t blocks its id for t+1..t+SPACING-1, so the history
    // only needs SPACING-1 stages.
    localparam int HIST_D = SPACING - 1;
    logic [HIST_D-1:0] hist_vld_r;
    id_t  [HIST_D-1:0] hist_id_r;

    // issue history, shifted every cycle with a bubble when nothing is granted
    always_ff @(posedge clk) begin
        if (!rst) begin
            hist_vld_r <= '0;
            hist_id_r  <= '0;
        end else begin
            hist_vld_r[0] <= grant_s;
            hist_id_r[0]  <= req.req_prod_id[idx_s];
            for (int k = 1; k < HIST_D; k++) begin
                hist_vld_r[k] <= hist_vld_r[k-1];
                hist_id_r[k]  <= hist_id_r[k-1];
            end
        end
    end

    // requester is blocked while its id is still in the history
    always_comb begin
        blocked_s = '0;
        for (int i = 0; i < REQ_N; i++) begin
            for (int k = 0; k < HIST_D; k++) begin
                blocked_s[i] = blocked_s[i] |
                               (hist_vld_r[k] && (hist_id_r[k] == req.req_prod_id[i]));
            end
        end
    end
`else
    // no spacing: nothing is ever blocked
    always_comb begin
        blocked_s = '0;
    end
`endif

    // candidates and same-cycle accept
    always_comb begin
        cand_s  = req.req_vld & ~blocked_s;
        run_s   = (state_r == RUN) && !i_busy;
        grant_s = run_s && any_s;
        if (run_s) begin
            req.req_rdy = gnt_oh_s;
        end else begin
            req.req_rdy = '0;
        end
    end

    v_upd_arb_rr #(
        .REQ_N (REQ_N)
    ) u_rr (
        .req (cand_s),
        .ptr (ptr_r),
        .gnt (gnt_oh_s),
        .idx (idx_s),
        .any (any_s)
    );

    // start-up FSM, RR pointer and registered update bus
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r         <= BOOT;
            boot_cnt_r      <= '0;
            ptr_r           <= '0;
            o_upd_vld_r     <= 1'b0;
            o_upd_prod_id_r <= '0;
            o_upd_cmd_r     <= '0;
            o_upd_key_r     <= '0;
            o_upd_size_r    <= '0;
            o_gnt_idx_r     <= '0;
            o_ready_r       <= 1'b0;
        end else begin
            case (state_r)
                BOOT: begin
                    if (boot_cnt_r == BCNT_W'(BOOT_CYC - 1)) begin
                        state_r <= WAIT_INIT;
                    end else begin
                        boot_cnt_r <= boot_cnt_r + BCNT_W'(1);
                    end
                end
                WAIT_INIT: begin
                    if (!i_busy) begin
                        state_r   <= RUN;
                        o_ready_r <= 1'b1;
                    end else begin
                        state_r <= WAIT_INIT;
                    end
                end
                RUN: begin
                    if (i_busy) begin
                        state_r   <= WAIT_INIT;
                        o_ready_r <= 1'b0;
                    end else begin
                        state_r <= RUN;
                    end
                end
                default: begin
                    state_r   <= BOOT;
                    o_ready_r <= 1'b0;
                end
            endcase
            o_upd_vld_r <= grant_s;
            if (grant_s) begin
                o_upd_prod_id_r <= req.req_prod_id[idx_s];
                o_upd_cmd_r     <= req.req_cmd[idx_s];
                o_upd_key_r     <= req.req_key[idx_s];
                o_upd_size_r    <= req.req_size[idx_s];
                o_gnt_idx_r     <= idx_s;
                if (idx_s == IDX_W'(REQ_N - 1)) begin
                    ptr_r <= '0;
                end else begin
                    ptr_r <= idx_s + IDX_W'(1);
                end
            end else begin
                ptr_r <= ptr_r;
            end
        end
    end

endmodule

// File: tb/tb_v_upd_arb.sv
// Bench for v_upd_arb: hand-derived vector table, directed corner sequences and
// random traffic compared against a cycle-level behavioural model.
module tb_v_upd_arb;
    import v_upd_arb_pkg::*;

    localparam int N        = 4;
    localparam int BOOT_CYC = 2;
    localparam int SPACING  = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        busy;
    logic        upd_vld;
    id_t         upd_id;
    cmd_t        upd_cmd;
    key_t        upd_key;
    size_t       upd_size;
    logic [1:0]  gnt_idx;
    logic        ready;

    v_upd_arb_if #(.REQ_N(N)) bus ();

    v_upd_arb #(.REQ_N(N), .BOOT_CYC(BOOT_CYC), .SPACING(SPACING)) dut (
        .clk             (clk),
        .rst             (rst),
        .req             (bus),
        .i_busy          (busy),
        .o_upd_vld_r     (upd_vld),
        .o_upd_prod_id_r (upd_id),
        .o_upd_cmd_r     (upd_cmd),
        .o_upd_key_r     (upd_key),
        .o_upd_size_r    (upd_size),
        .o_gnt_idx_r     (gnt_idx),
        .o_ready_r       (ready)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    // behavioural model state
    int  m_cyc = 0;
    int  m_since = 0;
    bit  m_run = 1'b0;
    int  m_ptr = 0;
    bit  m_vld = 1'b0;
    int  m_id = 0, m_cmd = 0, m_key = 0, m_size = 0, m_idx = 0;
    bit  m_ready = 1'b0;
    int  last_issue [16];
    logic [N-1:0] rdy_snap;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, m_cyc, act, exp);
    endtask

    function automatic bit m_blocked(input int j);
`ifdef V_UPD_ARB_SPACING_EN
        return (m_cyc - last_issue[int'(bus.req_prod_id[j])]) < SPACING;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int m_winner();
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (bus.req_vld[j] && !m_blocked(j)) return j;
        end
        return -1;
    endfunction

    task automatic m_clear();
        for (int k = 0; k < 16; k++) last_issue[k] = -100;
    endtask

    // one clock: inputs already applied; check comb accept, clock, check registers
    task automatic step();
        int w;
        logic [N-1:0] exp_rdy;
        #2;
        w = m_winner();
        exp_rdy = (m_run && !busy && w >= 0) ? N'(1) << w : '0;
        rdy_snap = bus.req_rdy;
        if (rst) check("req_rdy", 32'(bus.req_rdy), 32'(exp_rdy));
        @(posedge clk);
        if (!rst) begin
            m_since = 0; m_run = 1'b0; m_ptr = 0; m_vld = 1'b0;
            m_id = 0; m_cmd = 0; m_key = 0; m_size = 0; m_idx = 0; m_ready = 1'b0;
            m_clear();
        end else begin
            m_vld = m_run && !busy && (w >= 0);
            if (m_vld) begin
                m_id   = int'(bus.req_prod_id[w]);
                m_cmd  = int'(bus.req_cmd[w]);
                m_key  = int'(bus.req_key[w]);
                m_size = int'(bus.req_size[w]);
                m_idx  = w;
                m_ptr  = (w + 1) % N;
                last_issue[m_id] = m_cyc;
            end
            if (m_since < BOOT_CYC) begin
                m_since++;
                m_run = 1'b0;
            end else begin
                m_run = !busy;
            end
            m_ready = m_run;
        end
        m_cyc++;
        #1;
        check("upd_vld", 32'(upd_vld), 32'(m_vld));
        check("upd_prod_id", 32'(upd_id), 32'(m_id));
        check("upd_cmd", 32'(upd_cmd), 32'(m_cmd));
        check("upd_key", 32'(upd_key), 32'(m_key));
        check("upd_size", 32'(upd_size), 32'(m_size));
        check("gnt_idx", 32'(gnt_idx), 32'(m_idx));
        check("ready", 32'(ready), 32'(m_ready));
    endtask

    typedef struct {
        bit         rst;
        bit         busy;
        logic [3:0] vld;
        logic [3:0] exp_rdy;
        bit         exp_vld;
        int         exp_idx;
        bit         exp_ready;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit r, input bit b, input logic [3:0] v, input logic [3:0] er,
                       input bit ev, input int ei, input bit ery);
        vec_t t;
        t.rst = r; t.busy = b; t.vld = v; t.exp_rdy = er;
        t.exp_vld = ev; t.exp_idx = ei; t.exp_ready = ery;
        tbl.push_back(t);
    endtask

    task automatic bring_up();
        rst = 1'b0; busy = 1'b0; bus.req_vld = '0;
        step();
        rst = 1'b1;
        for (int k = 0; k < BOOT_CYC + 1; k++) step();
    endtask

    int issue_cyc[$];
    int issue_idx[$];

    initial begin
        m_clear();
        rst = 1'b0; busy = 1'b1;
        bus.req_vld = '0;
        for (int i = 0; i < N; i++) begin
            bus.req_prod_id[i] = id_t'(8 + i);
            bus.req_cmd[i]     = cmd_t'(i);
            bus.req_key[i]     = key_t'(8'h20 + i);
            bus.req_size[i]    = size_t'(8'h40 + i);
        end
        step();

`ifndef V_UPD_ARB_SPACING_EN
        // boot, busy hold-off, full round robin, busy pulse, reset, wrap
        add(0, 1, 4'hF, 4'h0, 0, 0, 0);
        add(1, 0, 4'hF, 4'h0, 0, 0, 0);
        add(1, 1, 4'hF, 4'h0, 0, 0, 0);
        for (int k = 0; k < 3; k++) add(1, 1, 4'hF, 4'h0, 0, 0, 0);
        add(1, 0, 4'hF, 4'h0, 0, 0, 1);
        for (int k = 0; k < 8; k++) add(1, 0, 4'hF, 4'(1 << (k % 4)), 1, k % 4, 1);
        add(1, 1, 4'hF, 4'h0, 0, 3, 0);
        add(1, 0, 4'hF, 4'h0, 0, 3, 1);
        add(1, 0, 4'hF, 4'h1, 1, 0, 1);
        add(1, 0, 4'hF, 4'h2, 1, 1, 1);
        add(0, 0, 4'hF, 4'h0, 0, 0, 0);
        add(1, 0, 4'hF, 4'h0, 0, 0, 0);
        add(1, 0, 4'hF, 4'h0, 0, 0, 0);
        add(1, 0, 4'hF, 4'h0, 0, 0, 1);
        add(1, 0, 4'hF, 4'h1, 1, 0, 1);
        add(1, 0, 4'h9, 4'h8, 1, 3, 1);
        add(1, 0, 4'h3, 4'h1, 1, 0, 1);
        for (int r = 0; r < tbl.size(); r++) begin
            rst = tbl[r].rst; busy = tbl[r].busy; bus.req_vld = tbl[r].vld;
            step();
            if (tbl[r].rst) check($sformatf("tbl%0d_rdy", r), 32'(rdy_snap), 32'(tbl[r].exp_rdy));
            check($sformatf("tbl%0d_vld", r), 32'(upd_vld), 32'(tbl[r].exp_vld));
            check($sformatf("tbl%0d_idx", r), 32'(gnt_idx), 32'(tbl[r].exp_idx));
            check($sformatf("tbl%0d_ready", r), 32'(ready), 32'(tbl[r].exp_ready));
        end
`endif

        // single requester streams one update per cycle, one cycle late
        bring_up();
        bus.req_vld = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            bus.req_prod_id[2] = id_t'(k);
            bus.req_key[2]     = key_t'(8'h10 + k);
            step();
            check("single_vld", 32'(upd_vld), 32'd1);
            check("single_key", 32'(upd_key), 32'(8'h10 + k));
        end

        // two requesters sharing prod_id 7
        bring_up();
        bus.req_vld = 4'b0011;
        bus.req_prod_id[0] = id_t'(7);
        bus.req_prod_id[1] = id_t'(7);
        for (int k = 0; k < 30; k++) begin
            step();
            if (upd_vld) begin
                issue_cyc.push_back(m_cyc);
                issue_idx.push_back(int'(gnt_idx));
            end
        end
`ifdef V_UPD_ARB_SPACING_EN
        check("same_id_issue_count", 32'(issue_cyc.size()), 32'd6);
        for (int k = 1; k < issue_cyc.size(); k++) begin
            check("same_id_gap", 32'(issue_cyc[k] - issue_cyc[k-1]), 32'(SPACING));
            check("same_id_alt", 32'(issue_idx[k]), 32'(1 - issue_idx[k-1]));
        end
`else
        check("same_id_issue_count", 32'(issue_cyc.size()), 32'd30);
        for (int k = 1; k < issue_cyc.size(); k++) begin
            check("same_id_alt", 32'(issue_idx[k]), 32'(1 - issue_idx[k-1]));
        end
`endif

        // random traffic against the model
        for (int c = 0; c < 400; c++) begin
            rst  = ($urandom_range(0, 99) != 0);
            busy = ($urandom_range(0, 9) == 0);
            bus.req_vld = 4'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) begin
                bus.req_prod_id[i] = id_t'($urandom_range(0, 3));
                bus.req_cmd[i]     = cmd_t'($urandom_range(0, 3));
                bus.req_key[i]     = key_t'($urandom_range(0, 255));
                bus.req_size[i]    = size_t'($urandom_range(0, 255));
            end
            step();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
